pipe_issue_ctrl: RTL and testbench
==================================

# pipe_issue_ctrl

Issue scheduler for the four-stage register/ALU/writeback/store pipeline. Two requesters submit instructions (rs1, rs2, rd, func, addr). The block arbitrates between them round-robin and holds back any instruction whose source register is still being written by an in-flight instruction (RAW scoreboard). It presents one instruction per cycle to the pipeline's stage-1 inputs and supports a drain/flush sequence.

## Interface
Parameters:
- WB_LAT, default 3: cycles from issue until the destination register is written back; this is the scoreboard depth, legal range 1–8.
- MAX_FUNC, default 11: highest legal func code; larger codes are rejected.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req0, req1  in  1 each  requester valid.
- rs1_0, rs2_0, rd_0, func_0  in  4 each  requester-0 fields; addr_0  in  8.
- rs1_1, rs2_1, rd_1, func_1  in  4 each  requester-1 fields; addr_1  in  8.
- gnt0, gnt1  out  1 each  combinational accept; a transfer occurs on an edge where reqN and gntN are both high.
- err0, err1  out  1 each  registered one-cycle pulse when an illegal func is rejected.
- iss_valid  out  1  registered; the iss_* fields are valid this cycle.
- iss_rs1, iss_rs2, iss_rd, iss_func  out  4 each; iss_addr  out  8.
- flush  in  1  level request: stop accepting and drain.
- flush_done  out  1  registered; high while in DRAINED.
- busy  out  1  high when any scoreboard entry is valid.

## Operation
- Candidate selection: if only one request is present, it is the candidate. If both are present, the candidate is the requester indicated by the round-robin pointer `last`. `last` resets to 1, so requester 0 wins the first tie.
- Illegal func (func > MAX_FUNC): the candidate is accepted (gnt high) but not issued. errN pulses on the next cycle, and the scoreboard is not loaded.
- Hazard: the candidate stalls if its rs1 or rs2 equals the rd of any valid scoreboard entry. While stalled, gnt is 0 for both requesters and iss_valid is 0 next cycle.
- Stalls are not bypassed by the other requester: the arbiter holds the same candidate until it issues. This keeps order fair.
- On issue: iss_* load the candidate fields, iss_valid=1, scoreboard[0] ← {1, rd}, and `last` ← the winner.
- Scoreboard: a WB_LAT-deep shift register of {valid, rd} entries, shifted every cycle. An entry is removed after WB_LAT cycles.
- Requesters hold their fields stable while req is high, up to and including the grant cycle.
- State machine:
  - RUN: normal arbitration.
  - RUN→DRAIN: when flush=1. No grants in DRAIN.
  - DRAIN→DRAINED: when the scoreboard is empty.
  - DRAINED→RUN: when flush=0.
  - Flush asserted in the same cycle as a legal, hazard-free candidate: flush wins, and no grant is given.

## Timing
- Reset values: iss_valid=0, all iss_* fields=0, err0/err1=0, flush_done=0, busy=0, state=RUN, scoreboard all invalid, last=1.
- gnt is combinational from req, the fields, scoreboard, state and flush.
- iss_* appear one cycle after the grant edge.
- Issue-to-clear: an rd issued at edge t blocks dependent instructions through edge t+WB_LAT−1. A dependent instruction is granted at edge t+WB_LAT at the earliest.
- Throughput: one issue per cycle when there are no hazards.
- An asserted rst cancels any pending candidate.

## Configuration
- ISSUE_STATS_EN, when defined, adds three outputs: issue_cnt (16), stall_cnt (16) and err_cnt (8).
  - Each is a saturating counter, cleared by rst.
  - stall_cnt increments on every cycle a candidate exists but is blocked by a hazard; DRAIN cycles are not counted.
- When ISSUE_STATS_EN is not defined, these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset then idle: all outputs 0 and gnt0=gnt1=0. Pulse rst mid-issue: iss_valid=0 and busy=0 immediately.
- req0 with {rs1=1, rs2=2, rd=3, func=0, addr=8'h10} and no hazard → gnt0 high that cycle; next cycle iss_valid=1 with identical fields; busy=1 for 3 cycles.
- Hazard with WB_LAT=3: issue rd=5, then req0 with rs1=5 → gnt0 low for 2 cycles, granted on the 3rd edge after the first issue; stall_cnt=2 if ISSUE_STATS_EN is defined.
- req0 and req1 held continuously with no hazards → grants alternate 0,1,0,1; an issue occurs every cycle.
- req1 with func=12 → gnt1=1, err1 pulses for one cycle, iss_valid stays 0, and the scoreboard is unchanged.
- flush while two instructions are in flight → no grants; flush_done rises after the last entry clears (≤3 cycles). Deassert flush → a grant is possible on the next cycle.

Source files
------------

// File: rtl/pipe_issue_ctrl.sv
// Two-requester round-robin issue scheduler with a RAW scoreboard and a flush/drain sequence.
// Optional saturating statistics counters are enabled with `define ISSUE_STATS_EN.
module pipe_issue_ctrl #(
    parameter int unsigned WB_LAT   = 3,
    parameter int unsigned MAX_FUNC = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] rs1_0,
    input  logic [3:0] rs2_0,
    input  logic [3:0] rd_0,
    input  logic [3:0] func_0,
    input  logic [7:0] addr_0,
    input  logic [3:0] rs1_1,
    input  logic [3:0] rs2_1,
    input  logic [3:0] rd_1,
    input  logic [3:0] func_1,
    input  logic [7:0] addr_1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       err0,
    output logic       err1,
    output logic       iss_valid,
    output logic [3:0] iss_rs1,
    output logic [3:0] iss_rs2,
    output logic [3:0] iss_rd,
    output logic [3:0] iss_func,
    output logic [7:0] iss_addr,
    input  logic       flush,
    output logic       flush_done,
    output logic       busy
`ifdef ISSUE_STATS_EN
   ,output logic [15:0] issue_cnt,
    output logic [15:0] stall_cnt,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DRAINED
    } state_t;

    state_t state, state_nxt;

    logic [WB_LAT-1:0]      sb_vld;
    logic [WB_LAT-1:0][3:0] sb_rd;
    logic                   last;
    logic                   hold_vld;
    logic                   hold_id;

    logic       cand_vld;
    logic       cand_id;
    logic [3:0] c_rs1, c_rs2, c_rd, c_func;
    logic [7:0] c_addr;
    logic       illegal;
    logic       hazard;
    logic       accept;
    logic       issue;

    // A stalled candidate keeps ownership until it is accepted, so the other
    // requester cannot overtake it while the hazard resolves.
    always_comb begin
        cand_vld = req0 | req1;
        if (hold_vld && (hold_id ? req1 : req0))
            cand_id = hold_id;
        else if (req0 && req1)
            cand_id = ~last;
        else
            cand_id = req1 & ~req0;

        c_rs1  = cand_id ? rs1_1  : rs1_0;
        c_rs2  = cand_id ? rs2_1  : rs2_0;
        c_rd   = cand_id ? rd_1   : rd_0;
        c_func = cand_id ? func_1 : func_0;
        c_addr = cand_id ? addr_1 : addr_0;

        illegal = {28'd0, c_func} > MAX_FUNC;

        // The oldest entry is being written back this cycle and no longer blocks.
        hazard = 1'b0;
        for (int unsigned i = 0; i + 1 < WB_LAT; i++) begin
            if (sb_vld[i] && (sb_rd[i] == c_rs1 || sb_rd[i] == c_rs2))
                hazard = 1'b1;
        end

        accept = (state == ST_RUN) && !flush && cand_vld && (illegal || !hazard);
        issue  = accept && !illegal;
        gnt0   = accept && !cand_id;
        gnt1   = accept && cand_id;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:     if (flush) state_nxt = ST_DRAIN;
            ST_DRAIN:   if (sb_vld == '0) state_nxt = ST_DRAINED;
            ST_DRAINED: if (!flush) state_nxt = ST_RUN;
            default:    state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_rs1   <= '0;
            iss_rs2   <= '0;
            iss_rd    <= '0;
            iss_func  <= '0;
            iss_addr  <= '0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            last      <= 1'b1;
            hold_vld  <= 1'b0;
            hold_id   <= 1'b0;
            sb_vld    <= '0;
            sb_rd     <= '0;
        end else begin
            iss_valid <= issue;
            err0      <= accept && illegal && !cand_id;
            err1      <= accept && illegal && cand_id;
            if (issue) begin
                iss_rs1  <= c_rs1;
                iss_rs2  <= c_rs2;
                iss_rd   <= c_rd;
                iss_func <= c_func;
                iss_addr <= c_addr;
                last     <= cand_id;
            end
            if (accept) begin
                hold_vld <= 1'b0;
            end else if (state == ST_RUN && cand_vld) begin
                hold_vld <= 1'b1;
                hold_id  <= cand_id;
            end
            for (int unsigned i = 1; i < WB_LAT; i++) begin
                sb_vld[i] <= sb_vld[i-1];
                sb_rd[i]  <= sb_rd[i-1];
            end
            sb_vld[0] <= issue;
            sb_rd[0]  <= c_rd;
        end
    end

    assign flush_done = (state == ST_DRAINED);
    assign busy       = |sb_vld;

`ifdef ISSUE_STATS_EN
    logic stall;
    assign stall = (state == ST_RUN) && cand_vld && !illegal && hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (issue && issue_cnt != '1)
                issue_cnt <= issue_cnt + 16'd1;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 16'd1;
            if (accept && illegal && err_cnt != '1)
                err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Self-checking bench for pipe_issue_ctrl: a cycle-level issue model plus directed literal checks.
module tb_pipe_issue_ctrl;

    localparam int WB = 3;
    localparam int MF = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, flush = 1'b0;
    logic [3:0] rs1_0 = '0, rs2_0 = '0, rd_0 = '0, func_0 = '0;
    logic [3:0] rs1_1 = '0, rs2_1 = '0, rd_1 = '0, func_1 = '0;
    logic [7:0] addr_0 = '0, addr_1 = '0;
    logic       gnt0, gnt1, err0, err1, iss_valid, flush_done, busy;
    logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0] iss_addr;
`ifdef ISSUE_STATS_EN
    logic [15:0] issue_cnt, stall_cnt;
    logic [7:0]  err_cnt;
`endif

    pipe_issue_ctrl #(.WB_LAT(WB), .MAX_FUNC(MF)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .rs1_0(rs1_0), .rs2_0(rs2_0), .rd_0(rd_0), .func_0(func_0), .addr_0(addr_0),
        .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1), .func_1(func_1), .addr_1(addr_1),
        .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1), .iss_valid(iss_valid),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_func(iss_func),
        .iss_addr(iss_addr), .flush(flush), .flush_done(flush_done), .busy(busy)
`ifdef ISSUE_STATS_EN
       ,.issue_cnt(issue_cnt), .stall_cnt(stall_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int t; logic [3:0] rd; } ent_t;
    ent_t       inflight[$];
    int         cyc;
    int         owner;     // requester that holds the arbiter after a stall, -1 if none
    int         prev_win;  // requester that issued most recently
    int         mode;      // 0 running, 1 draining, 2 drained
    logic       m_iss_valid, m_err0, m_err1;
    logic [23:0] m_iss;

    function automatic logic m_busy();
        foreach (inflight[i]) if (cyc - inflight[i].t <= WB - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_eval(output int who, output logic acc, output logic ill,
                                   output logic [23:0] flds);
        logic [3:0] a, b;
        logic haz;
        who = -1;
        if (owner == 0 && req0) who = 0;
        else if (owner == 1 && req1) who = 1;
        else if (req0 && req1) who = (prev_win == 0) ? 1 : 0;
        else if (req0) who = 0;
        else if (req1) who = 1;
        flds = (who == 1) ? {rs1_1, rs2_1, rd_1, func_1, addr_1}
                          : {rs1_0, rs2_0, rd_0, func_0, addr_0};
        a = flds[23:20];
        b = flds[19:16];
        ill = int'(flds[11:8]) > MF;
        haz = 1'b0;
        foreach (inflight[i])
            if (cyc - inflight[i].t < WB - 1 && (inflight[i].rd == a || inflight[i].rd == b))
                haz = 1'b1;
        acc = (who >= 0) && mode == 0 && !flush && (ill || !haz);
    endfunction

    always @(posedge clk or posedge rst) begin
        int who;
        logic acc, ill;
        logic [23:0] f;
        if (rst) begin
            inflight.delete();
            cyc = 0; owner = -1; prev_win = 1; mode = 0;
            m_iss_valid = 0; m_err0 = 0; m_err1 = 0; m_iss = '0;
        end else begin
            m_eval(who, acc, ill, f);
            m_err0 = acc && ill && who == 0;
            m_err1 = acc && ill && who == 1;
            m_iss_valid = acc && !ill;
            if (m_iss_valid) begin
                m_iss = f;
                prev_win = who;
            end
            if (acc) owner = -1;
            else if (who >= 0 && mode == 0) owner = who;
            if (mode == 0 && flush) mode = 1;
            else if (mode == 1 && !m_busy()) mode = 2;
            else if (mode == 2 && !flush) mode = 0;
            cyc++;
            if (m_iss_valid) inflight.push_back('{cyc, f[15:12]});
            while (inflight.size() > 0 && cyc - inflight[0].t > WB - 1) void'(inflight.pop_front());
        end
    end

    always @(negedge clk) begin
        int who;
        logic acc, ill;
        logic [23:0] f;
        if (!rst) begin
            m_eval(who, acc, ill, f);
            chk("m_gnt0", gnt0, acc && who == 0);
            chk("m_gnt1", gnt1, acc && who == 1);
            chk("m_iss_valid", iss_valid, m_iss_valid);
            if (m_iss_valid)
                chk("m_iss_fields", {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, m_iss);
            chk("m_err0", err0, m_err0);
            chk("m_err1", err1, m_err1);
            chk("m_busy", busy, m_busy());
            chk("m_flush_done", flush_done, mode == 2);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [3:0] a, b, d, fn, input logic [7:0] ad);
        req0 = 1; rs1_0 = a; rs2_0 = b; rd_0 = d; func_0 = fn; addr_0 = ad;
    endtask

    task automatic set1(input logic [3:0] a, b, d, fn, input logic [7:0] ad);
        req1 = 1; rs1_1 = a; rs2_1 = b; rd_1 = d; func_1 = fn; addr_1 = ad;
    endtask

    initial begin
        logic seen;
        repeat (2) @(negedge clk);
        #1 rst = 0;

        // reset / idle
        @(negedge clk);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_iss", {iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, 0);
        chk("rst_misc", {err0, err1, flush_done, busy}, 0);

        // single issue, busy for WB_LAT cycles
        tick();
        set0(4'd1, 4'd2, 4'd3, 4'd0, 8'h10);
        @(negedge clk);
        chk("single_gnt0", gnt0, 1);
        tick();
        req0 = 0;
        chk("single_iss", {iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr},
            {1'b1, 4'd1, 4'd2, 4'd3, 4'd0, 8'h10});
        for (int k = 0; k < 4; k++) begin
            chk("single_busy", busy, k < 3);
            tick();
        end

        // RAW hazard on rd=5
        set0(4'd4, 4'd4, 4'd5, 4'd1, 8'h20);
        @(negedge clk);
        chk("haz_first_gnt", gnt0, 1);
        tick();
        set0(4'd5, 4'd0, 4'd6, 4'd1, 8'h21);
        @(negedge clk);
        chk("haz_stall1", gnt0, 0);
        tick();
        @(negedge clk);
        chk("haz_stall2", gnt0, 0);
        tick();
        @(negedge clk);
        chk("haz_release", gnt0, 1);
        tick();
        req0 = 0;
        chk("haz_iss", {iss_valid, iss_rs1, iss_rd}, {1'b1, 4'd5, 4'd6});
`ifdef ISSUE_STATS_EN
        chk("stall_cnt", stall_cnt, 2);
`endif
        repeat (4) tick();

        // async reset in the middle of activity
        set0(4'd1, 4'd1, 4'd4, 4'd0, 8'h70);
        tick();
        req0 = 0;
        chk("pre_rst_iss", {iss_valid, busy}, 2'b11);
        #2 rst = 1;
        #1;
        chk("rst_async", {iss_valid, busy}, 0);
        @(negedge clk);
        #1 rst = 0;
        tick();

        // round-robin alternation
        set0(4'd7, 4'd7, 4'd8, 4'd2, 8'h30);
        set1(4'd9, 4'd9, 4'd10, 4'd3, 8'h40);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_gnt", {gnt0, gnt1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            chk("rr_iss", {iss_valid, iss_rd}, {1'b1, (k % 2 == 0) ? 4'd8 : 4'd10});
        end
        req0 = 0; req1 = 0;
        repeat (4) tick();

        // illegal func on requester 1, then highest legal func on requester 0
        set1(4'd1, 4'd1, 4'd2, 4'd12, 8'h50);
        @(negedge clk);
        chk("ill_gnt1", gnt1, 1);
        tick();
        req1 = 0;
        chk("ill_err", {err1, err0, iss_valid, busy}, 4'b1000);
        tick();
        chk("ill_err_pulse", err1, 0);
        set0(4'd1, 4'd1, 4'd2, 4'd11, 8'h51);
        @(negedge clk);
        chk("max_func_gnt", gnt0, 1);
        tick();
        req0 = 0;
        chk("max_func_iss", {iss_valid, iss_func, err0}, {1'b1, 4'd11, 1'b0});
        repeat (4) tick();

        // flush with two instructions in flight
        set0(4'd2, 4'd2, 4'd11, 4'd0, 8'h60);
        tick();
        set0(4'd3, 4'd3, 4'd12, 4'd0, 8'h61);
        tick();
        flush = 1;
        set0(4'd4, 4'd4, 4'd13, 4'd0, 8'h62);
        @(negedge clk);
        chk("flush_block", gnt0, 0);
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            if (flush_done) seen = 1;
            else begin
                @(negedge clk);
                chk("flush_no_gnt", gnt0, 0);
            end
        end
        chk("flush_done_rise", seen, 1);
        chk("flush_busy", busy, 0);
        flush = 0;
        @(negedge clk);
        chk("drained_no_gnt", gnt0, 0);
        tick();
        chk("resume_done_low", flush_done, 0);
        @(negedge clk);
        chk("resume_gnt", gnt0, 1);
        tick();
        req0 = 0;
        chk("resume_iss", {iss_valid, iss_addr}, {1'b1, 8'h62});
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
